// File: rtl/mag_comp_pkg.sv
// Shared constants for the bit-serial magnitude comparator.
// State encoding and default operand width.
package mag_comp_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int MAG_COMP_WIDTH = 8;
endpackage

// File: rtl/mag_bit_stage.sv
// One-bit comparator stage, purely combinational.
// MAG_COMP_SIGNED_EN: sign bit (is_msb) compares with inverted sense.
module mag_bit_stage (
    input  logic bit_a,
    input  logic bit_b,
    input  logic is_msb,
    output logic eq,
    output logic a_gt,
    output logic b_gt
);
    assign eq = (bit_a == bit_b);
`ifdef MAG_COMP_SIGNED_EN
    // A set sign bit means negative, so the zero-sign operand wins.
    assign a_gt = is_msb ? (~bit_a & bit_b) : (bit_a & ~bit_b);
    assign b_gt = is_msb ? (bit_a & ~bit_b) : (~bit_a & bit_b);
`else
    logic unused_msb;
    assign unused_msb = is_msb;
    assign a_gt = bit_a & ~bit_b;
    assign b_gt = ~bit_a & bit_b;
`endif
endmodule

// File: rtl/mag_comp_seq_ctrl.sv
// Bit-serial magnitude comparator controller, MSB to LSB, early exit.
// Optional two's-complement compare via MAG_COMP_SIGNED_EN.
module mag_comp_seq_ctrl
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = MAG_COMP_WIDTH,
    parameter int IDX_W = ($clog2(WIDTH) > 0 ? $clog2(WIDTH) : 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             bothEqual,
    output logic             A_greater,
    output logic             B_greater
);
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_bit;
    logic             busy_nxt;
    logic             done_nxt;
    logic             bit_eq;
    logic             bit_a_gt;
    logic             bit_b_gt;

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (idx == '0);

    mag_bit_stage u_bit (
        .bit_a  (a_reg[idx]),
        .bit_b  (b_reg[idx]),
        .is_msb (idx == IDX_W'(WIDTH - 1)),
        .eq     (bit_eq),
        .a_gt   (bit_a_gt),
        .b_gt   (bit_b_gt)
    );

    // State register; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        unique case (state)
            ST_IDLE: next_state = start ? ST_SCAN : ST_IDLE;
            ST_SCAN: next_state = (!bit_eq || last_bit) ? ST_DONE : ST_SCAN;
            ST_DONE: next_state = start ? ST_SCAN : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (next_state == ST_SCAN);
        done_nxt = (next_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            bothEqual <= 1'b0;
            A_greater <= 1'b0;
            B_greater <= 1'b0;
        end else if (accept) begin
            a_reg     <= A;
            b_reg     <= B;
            idx       <= IDX_W'(WIDTH - 1);
            bothEqual <= 1'b0;
            A_greater <= 1'b0;
            B_greater <= 1'b0;
        end else if (state == ST_SCAN) begin
            if (!bit_eq) begin
                A_greater <= bit_a_gt;
                B_greater <= bit_b_gt;
            end else if (last_bit) begin
                bothEqual <= 1'b1;
            end else begin
                idx <= idx - IDX_W'(1);
            end
        end
    end
endmodule
